// File: rtl/logic_addr_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : logic_addr_pkg
//  Description : Shared types and constants for the logic start-address
//                sequencer: FSM state encoding, default start-address table
//                and named request channel indices.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package logic_addr_pkg;

   // Sequencer FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RUN   = 2'd2
   } state_t;

   // Default start-address table, entry i at bits [i*8 +: 8]
   localparam logic [71:0] RST_TABLE_DEF = 72'h15_0F_20_0A_0A_08_06_03_00;

   // Request channel indices (0 = highest priority)
   localparam int unsigned CH_UP     = 0;
   localparam int unsigned CH_DOWN   = 1;
   localparam int unsigned CH_PWRON  = 2;
   localparam int unsigned CH_PWROFF = 3;
   localparam int unsigned CH_BF     = 4;
   localparam int unsigned CH_BT     = 5;
   localparam int unsigned CH_PRINT  = 6;
   localparam int unsigned CH_ZERO   = 7;
   localparam int unsigned CH_ONE    = 8;

endpackage
`default_nettype wire

// File: rtl/logic_addr_seq_prio_enc_lsb.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc_lsb
//  Description : Lowest-set-bit priority encoder. Returns the index of the
//                lowest set bit of i_vec and a flag saying any bit is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_enc_lsb
   import logic_addr_pkg::*;
#(
   parameter int N = 9,
   parameter int W = 4
) (
   input  logic [N-1:0] i_vec,
   output logic [W-1:0] o_idx,
   output logic         o_any
);

   // Scan from the top down so the lowest set bit is the last one written
   always_comb begin
      o_idx = '0;
      o_any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_idx = i[W-1:0];
            o_any = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/logic_addr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : logic_addr_seq
//  Description : Captures request pulses into sticky pending bits, arbitrates
//                them by fixed priority (bit 0 highest) and issues one start
//                address at a time from a writable table to the downstream
//                sequencer, staying busy until the sequencer reports done.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module logic_addr_seq
   import logic_addr_pkg::*;
#(
   parameter int                   N_REQ     = 9,
   parameter int                   AW        = 4,
   parameter int                   DW        = 8,
   parameter logic [N_REQ*DW-1:0]  RST_TABLE = RST_TABLE_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [AW-1:0]    l_addr,
   input  logic             l_wren,
   input  logic [DW-1:0]    l_data,
   output logic [DW-1:0]    l_rdata,
   output logic [DW-1:0]    start_addr,
   output logic             start_valid,
   input  logic             start_ready,
   output logic [AW-1:0]    grant_id,
   input  logic             seq_done,
   output logic             busy,
   output logic [N_REQ-1:0] pending
);

   localparam logic [AW:0] c_NREQ = N_REQ[AW:0];

   logic [DW-1:0]    r_table [N_REQ];
   logic [DW-1:0]    r_rdata;
   logic [N_REQ-1:0] r_pending;
   logic [N_REQ-1:0] w_clr;
   logic [AW-1:0]    w_idx;
   logic             w_any;
   logic             w_addr_ok;
   state_t           r_state;
   logic [DW-1:0]    r_start_addr;
   logic             r_start_valid;
   logic [AW-1:0]    r_grant_id;
   logic             r_busy;

   assign w_addr_ok = ({1'b0, l_addr} < c_NREQ);

   prio_enc_lsb #(
      .N (N_REQ),
      .W (AW)
   ) u_prio (
      .i_vec (r_pending),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   // One-hot clear for the channel being granted this cycle
   always_comb begin
      w_clr = '0;
      if (r_state == IDLE && w_any) begin
         w_clr[w_idx] = 1'b1;
      end
   end

   // Start-address table: reload defaults on reset, ignore out-of-range writes
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_REQ; i++) begin
            r_table[i] <= RST_TABLE[i*DW +: DW];
         end
      end else if (l_wren && w_addr_ok) begin
         r_table[l_addr] <= l_data;
      end
   end

   // Registered readback; a same-cycle write shows up one cycle later
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
      end else begin
         r_rdata <= w_addr_ok ? r_table[l_addr] : '0;
      end
   end

   // Sticky pending bits; a new request beats the grant clear
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~w_clr) | req;
      end
   end

   // Grant / issue / run sequencing with registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_start_addr  <= '0;
         r_start_valid <= 1'b0;
         r_grant_id    <= '0;
         r_busy        <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_grant_id    <= w_idx;
                  r_start_addr  <= r_table[w_idx];
                  r_start_valid <= 1'b1;
                  r_busy        <= 1'b1;
                  r_state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (start_ready) begin
                  r_start_valid <= 1'b0;
                  r_state       <= RUN;
               end
            end
            RUN: begin
               if (seq_done) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_start_valid <= 1'b0;
               r_busy        <= 1'b0;
               r_state       <= IDLE;
            end
         endcase
      end
   end

   assign l_rdata     = r_rdata;
   assign start_addr  = r_start_addr;
   assign start_valid = r_start_valid;
   assign grant_id    = r_grant_id;
   assign busy        = r_busy;
   assign pending     = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_logic_addr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_addr_seq
//  Description : Self-checking bench for logic_addr_seq. Expected grants are
//                queued as requests are driven and compared at each accepted
//                issue handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_addr_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic [8:0] req;
   logic [3:0] l_addr;
   logic       l_wren;
   logic [7:0] l_data;
   logic [7:0] l_rdata;
   logic [7:0] start_addr;
   logic       start_valid;
   logic       start_ready;
   logic [3:0] grant_id;
   logic       seq_done;
   logic       busy;
   logic [8:0] pending;

   typedef struct {
      logic [3:0] id;
      logic [7:0] addr;
   } exp_t;

   exp_t q_exp[$];
   int   n_cmp = 0;
   int   n_err = 0;

   logic [7:0] c_def_table [9] = '{8'h00, 8'h03, 8'h06, 8'h08, 8'h0A,
                                   8'h0A, 8'h20, 8'h0F, 8'h15};

   logic_addr_seq dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .l_addr      (l_addr),
      .l_wren      (l_wren),
      .l_data      (l_data),
      .l_rdata     (l_rdata),
      .start_addr  (start_addr),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .grant_id    (grant_id),
      .seq_done    (seq_done),
      .busy        (busy),
      .pending     (pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] id, input logic [7:0] addr);
      exp_t e;
      e.id   = id;
      e.addr = addr;
      q_exp.push_back(e);
   endtask

   task automatic done_pulse();
      seq_done = 1'b1;
      tick();
      seq_done = 1'b0;
   endtask

   // Scoreboard: compare every accepted issue against the next expected grant
   always @(negedge clk) begin
      if (!rst && start_valid && start_ready) begin
         if (q_exp.size() == 0) begin
            chk("sb_unexpected_issue", {28'd0, grant_id}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = q_exp.pop_front();
            chk("sb_grant_id", {28'd0, grant_id}, {28'd0, e.id});
            chk("sb_start_addr", {24'd0, start_addr}, {24'd0, e.addr});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst         = 1'b1;
      req         = '0;
      l_addr      = '0;
      l_wren      = 1'b0;
      l_data      = '0;
      start_ready = 1'b0;
      seq_done    = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_valid", {31'd0, start_valid}, 32'd0);
      chk("rst_pending", {23'd0, pending}, 32'd0);
      chk("rst_addr", {24'd0, start_addr}, 32'd0);
      chk("rst_grant", {28'd0, grant_id}, 32'd0);
      chk("rst_rdata", {24'd0, l_rdata}, 32'd0);
      rst = 1'b0;

      // Default table readback, plus an out-of-range index
      for (int i = 0; i < 9; i++) begin
         l_addr = i[3:0];
         tick();
         chk($sformatf("rd_def_%0d", i), {24'd0, l_rdata}, {24'd0, c_def_table[i]});
      end
      l_addr = 4'd15;
      tick();
      chk("rd_oor", {24'd0, l_rdata}, 32'd0);

      // Single request on channel 6
      start_ready = 1'b1;
      push(4'd6, 8'h20);
      req = 9'h040;
      tick();
      req = '0;
      chk("c6_pending", {23'd0, pending}, 32'h040);
      chk("c6_idle_busy", {31'd0, busy}, 32'd0);
      tick();
      chk("c6_valid", {31'd0, start_valid}, 32'd1);
      chk("c6_addr", {24'd0, start_addr}, 32'h20);
      chk("c6_grant", {28'd0, grant_id}, 32'd6);
      chk("c6_busy", {31'd0, busy}, 32'd1);
      tick();
      chk("c6_valid_drop", {31'd0, start_valid}, 32'd0);
      chk("c6_run_busy", {31'd0, busy}, 32'd1);
      done_pulse();
      chk("c6_done_busy", {31'd0, busy}, 32'd0);
      chk("c6_addr_kept", {24'd0, start_addr}, 32'h20);

      // Three simultaneous requests served in priority order
      push(4'd1, 8'h03);
      push(4'd2, 8'h06);
      push(4'd8, 8'h15);
      req = 9'h106;
      tick();
      req = '0;
      chk("multi_pend0", {23'd0, pending}, 32'h106);
      tick();
      chk("multi_pend1", {23'd0, pending}, 32'h104);
      tick();
      done_pulse();
      tick();
      chk("multi_pend2", {23'd0, pending}, 32'h100);
      tick();
      done_pulse();
      tick();
      chk("multi_pend3", {23'd0, pending}, 32'h000);
      tick();
      done_pulse();
      chk("multi_busy", {31'd0, busy}, 32'd0);

      // Table write during ISSUE must not alter the issued address
      start_ready = 1'b0;
      push(4'd0, 8'h00);
      req = 9'h001;
      tick();
      req = '0;
      tick();
      l_addr = 4'd0;
      l_wren = 1'b1;
      l_data = 8'h44;
      tick();
      l_wren = 1'b0;
      chk("wr_rd_old", {24'd0, l_rdata}, 32'h00);
      chk("wr_addr_hold", {24'd0, start_addr}, 32'h00);
      tick();
      chk("wr_rd_new", {24'd0, l_rdata}, 32'h44);
      chk("wr_addr_hold2", {24'd0, start_addr}, 32'h00);
      chk("wr_valid_hold", {31'd0, start_valid}, 32'd1);
      start_ready = 1'b1;
      tick();
      done_pulse();
      push(4'd0, 8'h44);
      req = 9'h001;
      tick();
      req = '0;
      tick();
      chk("wr_new_issue", {24'd0, start_addr}, 32'h44);
      tick();
      done_pulse();

      // Request re-asserted on the grant cycle is re-pended
      push(4'd3, 8'h08);
      push(4'd3, 8'h08);
      req = 9'h008;
      tick();
      tick();
      req = '0;
      chk("repend_pending", {23'd0, pending}, 32'h008);
      chk("repend_grant", {28'd0, grant_id}, 32'd3);
      tick();
      done_pulse();
      tick();
      chk("repend_again", {31'd0, start_valid}, 32'd1);
      chk("repend_clear", {23'd0, pending}, 32'h000);
      tick();
      done_pulse();

      // Reset during RUN aborts and restores the table
      l_addr = 4'd7;
      l_wren = 1'b1;
      l_data = 8'h99;
      tick();
      l_wren = 1'b0;
      push(4'd7, 8'h99);
      req = 9'h080;
      tick();
      req = 9'h002;
      tick();
      req = '0;
      tick();
      chk("rr_run_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rr_busy", {31'd0, busy}, 32'd0);
      chk("rr_pending", {23'd0, pending}, 32'd0);
      chk("rr_valid", {31'd0, start_valid}, 32'd0);
      chk("rr_addr", {24'd0, start_addr}, 32'd0);
      done_pulse();
      tick();
      tick();
      chk("rr_stray_busy", {31'd0, busy}, 32'd0);
      chk("rr_stray_valid", {31'd0, start_valid}, 32'd0);
      chk("rr_table_restored", {24'd0, l_rdata}, 32'h0F);

      chk("sb_empty", q_exp.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
